// File: rtl/sram_rw_arbiter_pkg.sv
// Shared types and sizing helpers for the SRAM read/write arbiter.
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of a round-robin pointer able to index n requesters.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Data bits covered by one write-mask bit.
  function automatic int lane_width(input int dw, input int mw);
    return dw / mw;
  endfunction

  localparam int NREQ_DEF   = 2;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W_DEF = 8;
  localparam int PTR_W_DEF  = ptr_width(NREQ_DEF);
  localparam int LANE_W_DEF = lane_width(DATA_W_DEF, MASK_W_DEF);

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Requester, response and SRAM-macro pins of the arbiter, bundled.
// slave = arbiter side, master = requesters plus the macro model.
interface sram_rw_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*MASK_W-1:0] req_wmask;
  logic [NREQ-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   sram_en;
  logic                   sram_wmode;
  logic [ADDR_W-1:0]      sram_addr;
  logic [MASK_W-1:0]      sram_wmask;
  logic [DATA_W-1:0]      sram_wdata;
  logic [DATA_W-1:0]      sram_rdata;
  logic                   init_busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, sram_rdata,
    output req_ready, resp_valid, resp_rdata,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, sram_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_busy
  );
endinterface

// File: rtl/sram_rw_arbiter_rr.sv
// Round-robin arbiter: one-hot grant of the first valid requester at or
// after the pointer; pointer advances past the winner on every grant.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int PTR_W = ptr_width(NREQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [NREQ-1:0]  valid,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;

  // Scan requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (en && !any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 on a grant, holds otherwise.
  always_ff @(posedge clock) begin
    if (reset)
      ptr <= '0;
    else if (any)
      ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares a single-port masked SRAM macro between NREQ requesters.
// Optional zero-init sweep after reset: define SRAM_ZERO_INIT_EN.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input logic               clock,
  input logic               reset,
  sram_rw_arbiter_if.slave  bus
);

  localparam int PTR_W = ptr_width(NREQ);

  state_t            state;
  logic              init_active;
  logic              run_en;
  logic [ADDR_W-1:0] init_addr;
  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  gidx;
  logic              any;
  logic [NREQ-1:0]   resp_q;

`ifdef SRAM_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_cnt;

  // Sequencer: sweep every address with zeros after reset, then run.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign init_addr = init_cnt;
`else
  // Sequencer: no sweep, arbitration is live straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state;
  end

  assign init_addr = '0;
`endif

  // Reset gates everything combinationally so the reset cycle itself is quiet.
  assign init_active   = (state == ST_INIT) && !reset;
  assign run_en        = (state == ST_RUN) && !reset;
  assign bus.init_busy = init_active;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .en        (run_en),
    .valid     (bus.req_valid),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any)
  );

  assign bus.req_ready = grant;

  // Macro pins: sweep writes take precedence, else the granted request.
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;
    if (init_active) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = init_addr;
      bus.sram_wmask = '1;
    end else if (any) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = bus.req_write[gidx];
      bus.sram_addr  = bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      bus.sram_wdata = bus.req_wdata[int'(gidx)*DATA_W +: DATA_W];
      // A read must never disturb the array, so its mask is zeroed.
      bus.sram_wmask = bus.req_write[gidx] ?
                       bus.req_wmask[int'(gidx)*MASK_W +: MASK_W] : '0;
    end
  end

  // Read response flag: set the cycle after a read grant, one cycle only.
  always_ff @(posedge clock) begin
    if (reset) resp_q <= '0;
    else       resp_q <= grant & ~bus.req_write;
  end

  // Reset in the response cycle drops the pending response.
  assign bus.resp_valid = reset ? '0 : resp_q;
  assign bus.resp_rdata = (|bus.resp_valid) ? bus.sram_rdata : '0;

endmodule
